cpu_trace_buffer: RTL
=====================

Name: cpu_trace_buffer

Overview:
- Parametrised commit-trace capture block for the RV32 core.
- Sits beside cpu_top and samples its retire-stage signals (pc, inst, rd, rd_data, writeback/load/store/stall flags) into a DEPTH-entry FIFO of trace records.
- Adds trigger-armed capture, a post-trigger commit count, drop accounting and a valid/ready drain port. The drain port feeds a UART dumper or a testbench.

Parameters:
- XLEN, 32, data/address width of the captured fields.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the post-trigger counter and the drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- commit_valid  in  1  an instruction retires this cycle
- commit_stall  in  1  core stalled; qualifies commit_valid off
- commit_pc  in  XLEN  pc of the retiring instruction
- commit_inst  in  32  instruction word
- commit_rd  in  5  destination register index
- commit_rd_data  in  XLEN  writeback data
- commit_wb  in  1  register writeback occurs
- commit_load  in  1  instruction is a load
- commit_store  in  1  instruction is a store
- cfg_start  in  1  pulse: begin a capture session
- cfg_stop  in  1  pulse: end the session
- cfg_clear  in  1  pulse: flush the FIFO and counters, go to IDLE
- cfg_trig_en  in  1  when 1, capture waits for a pc match
- cfg_trig_pc  in  XLEN  trigger pc
- cfg_post_cnt  in  CNT_W  commits to capture after the trigger; 0 = unbounded
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts the head record
- out_data  out  REC_W  head record
- state  out  2  current FSM state
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_cnt  out  CNT_W  records dropped while full; saturating
- overflow  out  1  sticky: at least one drop since the last clear

Behaviour:
- Record layout, MSB to LSB: {pc, inst, rd_data, rd[4:0], wb, load, store}. REC_W = 2*XLEN + 32 + 8.
- Reset and cfg_clear values: state = IDLE; FIFO empty (level = 0, out_valid = 0); drop_cnt = 0; overflow = 0; post counter = 0. out_data is don't-care while out_valid = 0.
- Capture event: commit_valid & ~commit_stall. Every other commit is ignored.
- FSM states:
  - IDLE = 0: cfg_start goes to ARMED if cfg_trig_en, otherwise to CAPTURE.
  - ARMED = 1: a capture event with commit_pc == cfg_trig_pc goes to CAPTURE. That triggering commit is itself captured and counted.
  - CAPTURE = 2: every capture event is pushed. The post counter increments per event, whether accepted or dropped. When cfg_post_cnt != 0 and the counter reaches cfg_post_cnt, the FSM goes to DONE on that same edge. That last event is still pushed.
  - DONE = 3: no capture. cfg_start re-enters ARMED or CAPTURE with the post counter zeroed. FIFO contents are kept.
  - cfg_stop in ARMED or CAPTURE goes to DONE. It has no effect in IDLE or DONE.
- Priority: rst > cfg_clear > cfg_stop > cfg_start. If start and stop arrive in the same cycle, stop wins; from IDLE the FSM stays in IDLE.
- FIFO:
  - Storage is registered.
  - out_data reads the head entry combinationally.
  - A push at edge N is visible on out_valid/out_data after edge N (1-cycle latency).
  - Pop on out_valid & out_ready.
- FIFO full:
  - A push with no pop is dropped: drop_cnt increments (saturating at 2^CNT_W-1) and overflow is set.
  - A push with a pop while full succeeds; level is unchanged, no drop.
- FIFO empty: out_ready is ignored and level never underflows.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is derived from a separate occupancy counter.
- Draining is allowed in every state, including IDLE and DONE.

Optional Feature:
- Macro: TRACE_MEM_EN.
- Defined:
  - Adds inputs commit_mem_addr (XLEN) and commit_mem_wdata (XLEN).
  - The record becomes {mem_addr, mem_wdata, base record} and REC_W grows by 2*XLEN.
  - For non-load/store commits, both added fields are stored as zero.
- Not defined: those ports are absent and the record is the base layout only.

Decomposition:
- Package cpu_trace_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, DONE);
  - REC_W computation and field offset localparams;
  - the trace_rec_t packed struct, with the mem fields under TRACE_MEM_EN.
- Sub-module trace_fifo: synchronous FIFO with full/empty/level and simultaneous push/pop. Parameters are WIDTH and DEPTH.

Test Plan:
- Reset, then cfg_start with trig_en = 0 and post_cnt = 0, then 3 commits at pc 0x0, 0x4, 0x8 → level = 3, records pop in order with the correct fields; state = CAPTURE.
- trig_en = 1, trig_pc = 0x100, post_cnt = 2, commits at 0xF8, 0xFC, 0x100, 0x104, 0x108 → exactly 0x100 and 0x104 are captured; state = DONE after the 0x104 edge.
- DEPTH = 16, out_ready = 0, 20 commits → level = 16, drop_cnt = 4, overflow = 1. Then a cycle with push and pop together → level stays 16 and drop_cnt stays 4.
- commit_valid = 1 with commit_stall = 1 for 5 cycles in CAPTURE → no pushes, post counter unchanged.
- cfg_start and cfg_stop asserted in the same cycle from IDLE → state stays IDLE. In CAPTURE with 5 entries, cfg_clear → level = 0, drop_cnt = 0, state = IDLE. A rst pulse gives the same result.
- TRACE_MEM_EN defined: a store with mem_addr 0x2000 and wdata 0xDEADBEEF → the record carries both values. An ALU op → both fields are zero.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and record geometry for the commit-trace buffer.
//   - trace_state_t : capture FSM encoding
//   - rec_width()   : record width for a given XLEN
//   - trace_rec_t   : packed record view at the default XLEN
// Optional macro TRACE_MEM_EN prepends {mem_addr, mem_wdata} to every record.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_t;

  localparam int TRACE_XLEN = 32;

`ifdef TRACE_MEM_EN
  localparam int MEM_FIELDS = 2;
`else
  localparam int MEM_FIELDS = 0;
`endif

  function automatic int rec_width(input int xlen);
    return (2 + MEM_FIELDS) * xlen + 32 + 8;
  endfunction

  localparam int TRACE_REC_W = rec_width(TRACE_XLEN);

  // Field offsets (LSB positions) at the default XLEN.
  localparam int STORE_BIT   = 0;
  localparam int LOAD_BIT    = 1;
  localparam int WB_BIT      = 2;
  localparam int RD_LSB      = 3;
  localparam int RD_DATA_LSB = 8;
  localparam int INST_LSB    = RD_DATA_LSB + TRACE_XLEN;
  localparam int PC_LSB      = INST_LSB + 32;

  typedef struct packed {
`ifdef TRACE_MEM_EN
    logic [TRACE_XLEN-1:0] mem_addr;
    logic [TRACE_XLEN-1:0] mem_wdata;
`endif
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic [TRACE_XLEN-1:0] rd_data;
    logic [4:0]            rd;
    logic                  wb;
    logic                  load;
    logic                  store;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered storage and combinational head read.
// Ports:
//   clk, rst (sync, active-high), clr (sync flush)
//   push/wr_data : write request; accepted when not full, or when full with a pop
//   pop          : read request; ignored while empty
//   rd_data      : head entry (don't-care while empty)
//   full, empty, level : status; level comes from a dedicated occupancy counter
module trace_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture block for the RV32 core.
// Samples retire-stage signals into a DEPTH-entry FIFO of trace records,
// with optional pc trigger, post-trigger commit limit, drop accounting and
// a valid/ready drain port.
// Ports:
//   clk, rst (sync, active-high)
//   commit_*        : retire-stage inputs; event = commit_valid & ~commit_stall
//   cfg_*           : session control (start/stop/clear pulses, trigger, limit)
//   out_valid/out_ready/out_data : drain port, head record
//   state, level, drop_cnt, overflow : status
// Optional macro TRACE_MEM_EN adds commit_mem_addr / commit_mem_wdata and
// prepends them to the record (zeroed for non-memory commits).
//
// state   | meaning
// IDLE    | no session; waiting for cfg_start
// ARMED   | waiting for a commit at cfg_trig_pc
// CAPTURE | pushing every commit event
// DONE    | session ended; FIFO kept, cfg_start restarts
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 16,
  localparam int REC_W = rec_width(XLEN),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic             commit_stall,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic [4:0]       commit_rd,
  input  logic [XLEN-1:0]  commit_rd_data,
  input  logic             commit_wb,
  input  logic             commit_load,
  input  logic             commit_store,
`ifdef TRACE_MEM_EN
  input  logic [XLEN-1:0]  commit_mem_addr,
  input  logic [XLEN-1:0]  commit_mem_wdata,
`endif
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_clear,
  input  logic             cfg_trig_en,
  input  logic [XLEN-1:0]  cfg_trig_pc,
  input  logic [CNT_W-1:0] cfg_post_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REC_W-1:0] out_data,
  output logic [1:0]       state,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  trace_state_t     state_q;
  logic [CNT_W-1:0] post_q;
  logic             evt;
  logic             push;
  logic             last_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic [REC_W-1:0] rec;

  assign evt  = commit_valid & ~commit_stall;
  assign push = evt & ((state_q == CAPTURE) ||
                       ((state_q == ARMED) && (commit_pc == cfg_trig_pc)));
  // This push is the one that reaches the configured post-trigger limit.
  assign last_evt = (cfg_post_cnt != '0) && ((post_q + 1'b1) == cfg_post_cnt);

`ifdef TRACE_MEM_EN
  logic mem_op;
  assign mem_op = commit_load | commit_store;
  assign rec = {mem_op ? commit_mem_addr  : {XLEN{1'b0}},
                mem_op ? commit_mem_wdata : {XLEN{1'b0}},
                commit_pc, commit_inst, commit_rd_data, commit_rd,
                commit_wb, commit_load, commit_store};
`else
  assign rec = {commit_pc, commit_inst, commit_rd_data, commit_rd,
                commit_wb, commit_load, commit_store};
`endif

  always_ff @(posedge clk) begin
    if (rst || cfg_clear) begin
      state_q <= IDLE;
      post_q  <= '0;
    end else begin
      if (push) post_q <= post_q + 1'b1;
      if (cfg_stop) begin
        if (state_q == ARMED || state_q == CAPTURE) state_q <= DONE;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (cfg_start) begin
              state_q <= cfg_trig_en ? ARMED : CAPTURE;
              post_q  <= '0;
            end
          end
          ARMED: begin
            if (push) state_q <= last_evt ? DONE : CAPTURE;
          end
          CAPTURE: begin
            if (push && last_evt) state_q <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (cfg_clear),
    .push    (push),
    .wr_data (rec),
    .pop     (out_ready),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Full with no pop in the same cycle is the only drop case.
  assign drop = push & fifo_full & ~out_ready;

  always_ff @(posedge clk) begin
    if (rst || cfg_clear) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign out_valid = ~fifo_empty;
  assign state     = state_q;

endmodule
